// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control stage.
//   MEM_B/MEM_H/MEM_W  : access size codes carried in mem_op[1:0]
//   MEM_UNS_BIT        : mem_op bit selecting zero-extension of loads
//   lsu_state_t        : control FSM states
//   lsu_wstrb()        : byte-lane strobes for a given size and byte offset
//   lsu_misaligned()   : illegal size or misaligned address
package lsu_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;
    localparam int         MEM_UNS_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS_REQ,
        ST_BUS_WAIT,
        ST_RSP
    } lsu_state_t;

    function automatic logic [3:0] lsu_wstrb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] base;
        case (size)
            MEM_B:   base = 4'b0001;
            MEM_H:   base = 4'b0011;
            MEM_W:   base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return base << off;
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = off[0];
            MEM_W:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/half/word out of a read word
// and sign- or zero-extends it. Purely combinational.
//   rdata   : word returned by the bus
//   offset  : byte offset of the access within the word
//   mem_op  : [1:0] size, [2] zero-extend
//   data    : right-justified, extended load result (0 for an illegal size)
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       offset,
    input  logic [2:0]       mem_op,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] shifted;
    logic             ext_bit;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        ext_bit = 1'b0;
        data    = '0;
        case (mem_op[1:0])
            MEM_B: begin
                ext_bit = shifted[7] & ~mem_op[MEM_UNS_BIT];
                data    = {{(WIDTH-8){ext_bit}}, shifted[7:0]};
            end
            MEM_H: begin
                ext_bit = shifted[15] & ~mem_op[MEM_UNS_BIT];
                data    = {{(WIDTH-16){ext_bit}}, shifted[15:0]};
            end
            MEM_W:   data = shifted;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage between execute and memory. Accepts one request at a
// time, issues a single word-aligned bus transaction with byte strobes, and
// returns the (extended) load result or a store/error completion to write-back.
//   req_*       : request handshake from execute (we, mem_op, addr, wdata, tag)
//   bus_req_*   : bus request channel (we, word address, lane-shifted data, strobes)
//   bus_resp_*  : bus response channel (read data or write ack)
//   rsp_*       : result handshake to write-back (rdata, err, tag)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for a request, req_ready=1
// ST_BUS_REQ  | bus_req_valid=1 with held payload until bus_req_ready
// ST_BUS_WAIT | bus_resp_ready=1, waiting for read data / write ack
// ST_RSP      | rsp_valid=1 with held result until rsp_ready
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_mem_op,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             bus_req_valid,
    input  logic             bus_req_ready,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_wdata,
    output logic [3:0]       bus_wstrb,
    input  logic             bus_resp_valid,
    output logic             bus_resp_ready,
    input  logic [WIDTH-1:0] bus_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag
);

    lsu_state_t       state;
    logic [2:0]       op_q;
    logic [1:0]       off_q;
    logic [1:0]       req_off;
    logic             req_bad;
    logic [WIDTH-1:0] load_data;

    assign req_off = req_addr[1:0];
    assign req_bad = lsu_misaligned(req_mem_op[1:0], req_off);

    lsu_load_align #(.WIDTH(WIDTH)) u_align (
        .rdata  (bus_rdata),
        .offset (off_q),
        .mem_op (op_q),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            req_ready      <= 1'b1;
            bus_req_valid  <= 1'b0;
            bus_resp_ready <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= '0;
            rsp_tag        <= '0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            bus_wstrb      <= 4'b0000;
            op_q           <= 3'b000;
            off_q          <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_mem_op;
                        off_q     <= req_off;
                        rsp_tag   <= req_tag;
                        rsp_err   <= req_bad;
                        rsp_rdata <= '0;
                        req_ready <= 1'b0;
                        bus_we    <= req_we;
                        bus_addr  <= {req_addr[WIDTH-1:2], 2'b00};
                        bus_wdata <= req_wdata << {req_off, 3'b000};
                        bus_wstrb <= req_we ? lsu_wstrb(req_mem_op[1:0], req_off) : 4'b0000;
                        // Faulting requests complete straight away without touching the bus.
                        if (req_bad) begin
                            rsp_valid <= 1'b1;
                            state     <= ST_RSP;
                        end else begin
                            bus_req_valid <= 1'b1;
                            state         <= ST_BUS_REQ;
                        end
                    end
                end
                ST_BUS_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid  <= 1'b0;
                        bus_resp_ready <= 1'b1;
                        state          <= ST_BUS_WAIT;
                    end
                end
                ST_BUS_WAIT: begin
                    if (bus_resp_valid) begin
                        bus_resp_ready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_rdata      <= bus_we ? '0 : load_data;
                        state          <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    bus_req_valid  <= 1'b0;
                    bus_resp_ready <= 1'b0;
                    rsp_valid      <= 1'b0;
                    req_ready      <= 1'b1;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus a random sweep.
// Expected responses are queued when a request is driven and popped when
// write-back accepts a result.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_mem_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_tag;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic        bus_resp_ready;
    logic [31:0] bus_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  rsp_tag;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  tag;
    } rsp_t;

    rsp_t sb_q[$];
    rsp_t sb_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   bus_cnt = 0;

    lsu_ctrl #(.WIDTH(32), .TAG_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_mem_op     (req_mem_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_tag        (req_tag),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_ready (bus_resp_ready),
        .bus_rdata      (bus_rdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .rsp_tag        (rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model
    function automatic logic m_err(input logic [2:0] op, input logic [1:0] a);
        case (op[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return a != 2'd0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] op, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = (a == 2'd2) ? w[31:16] : w[15:0];
        case (op[1:0])
            2'b00:   return op[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return op[2] ? {16'h0, h} : {{16{h[15]}}, h};
            2'b10:   return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] op, input logic [1:0] a);
        case (op[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return (a == 2'd0) ? 4'b0011 : 4'b1100;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Response scoreboard: compares each accepted result against the queue head.
    always @(negedge clk) begin
        if (rst_n && bus_req_valid && bus_req_ready) bus_cnt++;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, sb_e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, sb_e.err});
                chk("rsp_tag", {27'd0, rsp_tag}, {27'd0, sb_e.tag});
            end
        end
    end

    // One full transaction with a given number of bus-request and response stall cycles.
    task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] tag, input logic [31:0] rword,
                           input int bstall, input int rstall, input logic [31:0] e_rdata,
                           input logic e_err, input logic [3:0] e_strb, input logic [31:0] e_wdata);
        rsp_t e;
        int   c0;
        c0 = bus_cnt;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_mem_op = op;
        req_addr   = addr;
        req_wdata  = wdata;
        req_tag    = tag;
        e.rdata = e_err ? 32'h0 : e_rdata;
        e.err   = e_err;
        e.tag   = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        if (!e_err) begin
            for (int i = 0; i <= bstall; i++) begin
                bus_req_ready = (i == bstall);
                @(negedge clk);
                chk("bus_req_valid", {31'd0, bus_req_valid}, 32'd1);
                chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
                chk("bus_we", {31'd0, bus_we}, {31'd0, we});
                chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, e_strb});
                if (we) chk("bus_wdata", bus_wdata, e_wdata);
                chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
                chk("bus_resp_ready_early", {31'd0, bus_resp_ready}, 32'd0);
                @(posedge clk);
                #1;
            end
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'b1;
            bus_rdata      = rword;
            @(negedge clk);
            chk("bus_resp_ready", {31'd0, bus_resp_ready}, 32'd1);
            chk("bus_req_valid_wait", {31'd0, bus_req_valid}, 32'd0);
            @(posedge clk);
            #1;
            bus_resp_valid = 1'b0;
            bus_rdata      = 32'hDEAD_BEEF;
        end
        for (int i = 0; i <= rstall; i++) begin
            rsp_ready = (i == rstall);
            @(negedge clk);
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("req_ready_rsp", {31'd0, req_ready}, 32'd0);
            chk("bus_idle_rsp", {31'd0, bus_req_valid}, 32'd0);
            if (i < rstall) begin
                chk("rsp_hold_rdata", rsp_rdata, e.rdata);
                chk("rsp_hold_tag", {27'd0, rsp_tag}, {27'd0, tag});
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b0;
        chk("bus_txn_count", bus_cnt - c0, e_err ? 32'd0 : 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_we;
        logic [2:0]  r_op;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic [31:0] r_word;
        logic        r_err;

        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_we         = 1'b0;
        req_mem_op     = 3'b000;
        req_addr       = 32'h0;
        req_wdata      = 32'h0;
        req_tag        = 5'd0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_rdata      = 32'hDEAD_BEEF;
        rsp_ready      = 1'b0;

        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_bus_req_valid", {31'd0, bus_req_valid}, 32'd0);
        chk("rst_bus_resp_ready", {31'd0, bus_resp_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_tag", {27'd0, rsp_tag}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load byte, sign-extended
        run_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd1, 32'h80FF_1234, 0, 0,
                32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0);
        // Load half unsigned / signed
        run_txn(1'b0, 3'b101, 32'h8000_0002, 32'h0, 5'd2, 32'hBEEF_0000, 0, 0,
                32'h0000_BEEF, 1'b0, 4'b0000, 32'h0);
        run_txn(1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd3, 32'hBEEF_0000, 0, 0,
                32'hFFFF_BEEF, 1'b0, 4'b0000, 32'h0);
        // Store half at upper half
        run_txn(1'b1, 3'b001, 32'h8000_0006, 32'h1234_ABCD, 5'd4, 32'hDEAD_BEEF, 0, 0,
                32'h0, 1'b0, 4'b1100, 32'hABCD_0000);
        // Store byte at lane 3
        run_txn(1'b1, 3'b000, 32'h4000_0103, 32'h0000_005A, 5'd5, 32'h0, 0, 0,
                32'h0, 1'b0, 4'b1000, 32'h5A00_0000);
        // Misaligned word load, misaligned half store, illegal size
        run_txn(1'b0, 3'b010, 32'h8000_0002, 32'h0, 5'd17, 32'h0, 0, 0,
                32'h0, 1'b1, 4'b0000, 32'h0);
        run_txn(1'b1, 3'b001, 32'h8000_0001, 32'hFFFF_FFFF, 5'd18, 32'h0, 0, 1,
                32'h0, 1'b1, 4'b0000, 32'h0);
        run_txn(1'b0, 3'b011, 32'h8000_0000, 32'h0, 5'd19, 32'h0, 0, 0,
                32'h0, 1'b1, 4'b0000, 32'h0);
        // Backpressure on both sides
        run_txn(1'b0, 3'b010, 32'h8000_0008, 32'h0, 5'd21, 32'hCAFE_F00D, 3, 2,
                32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0);

        // Reset while waiting on the bus response
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_mem_op = 3'b010;
        req_addr   = 32'h8000_0010;
        req_tag    = 5'd9;
        @(posedge clk);
        #1;
        req_valid     = 1'b0;
        bus_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_req_ready = 1'b0;
        @(negedge clk);
        chk("abort_in_wait", {31'd0, bus_resp_ready}, 32'd1);
        #1;
        rst_n          = 1'b0;
        bus_resp_valid = 1'b1;
        bus_rdata      = 32'hBAD0_BAD0;
        #1;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_bus_resp_ready", {31'd0, bus_resp_ready}, 32'd0);
        chk("abort_bus_addr", bus_addr, 32'h0);
        chk("abort_rsp_tag", {27'd0, rsp_tag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("stale_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("stale_req_ready", {31'd0, req_ready}, 32'd1);
        bus_resp_valid = 1'b0;
        bus_rdata      = 32'hDEAD_BEEF;
        run_txn(1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd10, 32'h1122_3344, 0, 0,
                32'h1122_3344, 1'b0, 4'b0000, 32'h0);

        // Random sweep
        for (int k = 0; k < 24; k++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_op    = 3'($urandom_range(0, 7));
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_word  = $urandom;
            r_err   = m_err(r_op, r_addr[1:0]);
            run_txn(r_we, r_op, r_addr, r_wdata, 5'($urandom_range(0, 31)), r_word,
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    r_we ? 32'h0 : m_load(r_word, r_op, r_addr[1:0]), r_err,
                    r_we ? m_strb(r_op, r_addr[1:0]) : 4'b0000,
                    r_wdata << (8 * r_addr[1:0]));
        end

        @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
